// File: rtl/uart_fifo_pkg.sv
// Shared constants, read-mode encoding and depth helper for the UART FIFO slice.
package uart_fifo_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 5;

   typedef enum logic {
      MODE_STD  = 1'b0,
      MODE_FWFT = 1'b1
   } rd_mode_e;

   function automatic int depth_of(input int addr_w);
      return 32'd1 << addr_w;
   endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// Dual-port storage: synchronous write, read port either registered or asynchronous.
module fifo_ram_dp
   import uart_fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter bit REG_RD = 1'b1
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int DEPTH = depth_of(ADDR_W);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_q;

   // Array write port; the array itself is never reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Registered read port; same-edge write to this address returns the old word.
   always_ff @(posedge clk) begin
      if (n_reset) begin
         rd_q <= '0;
      end else if (re_i) begin
         rd_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = REG_RD ? rd_q : mem_q[raddr_i];

endmodule

// File: rtl/uart_fifo_prog.sv
// Synchronous FIFO with programmable thresholds, sticky error flags, flush and optional FWFT reads.
module uart_fifo_prog
   import uart_fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int FWFT   = 0
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rd_en,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic [ADDR_W:0]   afull_thr,
   input  logic [ADDR_W:0]   aempty_thr,
   output logic [ADDR_W:0]   data_count,
   output logic              empty,
   output logic              full,
   output logic              almst_full,
   output logic              almst_empty,
   output logic              overflow,
   output logic              underflow,
   input  logic              err_clr
);

   localparam int              DEPTH   = depth_of(ADDR_W);
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam rd_mode_e        MODE    = (FWFT != 0) ? MODE_FWFT : MODE_STD;

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              dvalid_q, dvalid_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic              empty_s, full_s;
   logic              wr_acc_s, rd_acc_s;
   logic              ram_we_s, ram_re_s;
   logic [DATA_W-1:0] ram_rdata_s;

   assign empty_s  = (count_q == '0);
   assign full_s   = (count_q == DEPTH_C);
   assign rd_acc_s = rd_en & ~empty_s;
   assign wr_acc_s = wr_en & (~full_s | rd_acc_s);

   // Memory ports are blocked while reset or flush discard the cycle's requests.
   assign ram_we_s = wr_acc_s & ~flush & ~n_reset;
   assign ram_re_s = rd_acc_s & ~flush & ~n_reset;

   // Next-state: reset beats flush beats normal accept/count/flag updates.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dvalid_d = dvalid_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      if (n_reset) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         dvalid_d = 1'b0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
      end else if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         dvalid_d = 1'b0;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
         endcase
         dvalid_d = rd_acc_s;
         // A fresh error in the clear cycle wins over err_clr.
         if (wr_en & ~wr_acc_s) begin
            ovf_d = 1'b1;
         end else if (err_clr) begin
            ovf_d = 1'b0;
         end else begin
            ovf_d = ovf_q;
         end
         if (rd_en & ~rd_acc_s) begin
            unf_d = 1'b1;
         end else if (err_clr) begin
            unf_d = 1'b0;
         end else begin
            unf_d = unf_q;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dvalid_q <= dvalid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
   end

   fifo_ram_dp #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .REG_RD (MODE == MODE_STD)
   ) u_ram (
      .clk     (clk),
      .n_reset (n_reset),
      .we_i    (ram_we_s),
      .waddr_i (wr_ptr_q),
      .wdata_i (data_in),
      .re_i    (ram_re_s),
      .raddr_i (rd_ptr_q),
      .rdata_o (ram_rdata_s)
   );

   assign data_out    = ram_rdata_s;
   assign data_valid  = (MODE == MODE_FWFT) ? ~empty_s : dvalid_q;
   assign data_count  = count_q;
   assign empty       = empty_s;
   assign full        = full_s;
   assign almst_full  = (count_q >= afull_thr);
   assign almst_empty = (count_q <= aempty_thr);
   assign overflow    = ovf_q;
   assign underflow   = unf_q;

endmodule

// File: tb/tb_uart_fifo_prog.sv
// Directed bench for uart_fifo_prog: one standard-read and one FWFT instance share the stimulus.
module tb_uart_fifo_prog;

   logic       clk = 1'b0;
   logic       n_reset, flush, wr_en, rd_en, err_clr;
   logic [7:0] data_in;
   logic [5:0] afull_thr, aempty_thr;

   logic [7:0] s_dout, f_dout;
   logic       s_dv, f_dv;
   logic [5:0] s_cnt, f_cnt;
   logic       s_empty, s_full, s_af, s_ae, s_ovf, s_unf;
   logic       f_empty, f_full, f_af, f_ae, f_ovf, f_unf;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   uart_fifo_prog #(.DATA_W(8), .ADDR_W(5), .FWFT(0)) u_std (
      .clk(clk), .n_reset(n_reset), .flush(flush), .wr_en(wr_en), .data_in(data_in),
      .rd_en(rd_en), .data_out(s_dout), .data_valid(s_dv), .afull_thr(afull_thr),
      .aempty_thr(aempty_thr), .data_count(s_cnt), .empty(s_empty), .full(s_full),
      .almst_full(s_af), .almst_empty(s_ae), .overflow(s_ovf), .underflow(s_unf),
      .err_clr(err_clr)
   );

   uart_fifo_prog #(.DATA_W(8), .ADDR_W(5), .FWFT(1)) u_fwft (
      .clk(clk), .n_reset(n_reset), .flush(flush), .wr_en(wr_en), .data_in(data_in),
      .rd_en(rd_en), .data_out(f_dout), .data_valid(f_dv), .afull_thr(afull_thr),
      .aempty_thr(aempty_thr), .data_count(f_cnt), .empty(f_empty), .full(f_full),
      .almst_full(f_af), .almst_empty(f_ae), .overflow(f_ovf), .underflow(f_unf),
      .err_clr(err_clr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_cnt"},   32'(s_cnt),   32'd0);
      chk({tag, "_empty"}, 32'(s_empty), 32'd1);
      chk({tag, "_full"},  32'(s_full),  32'd0);
      chk({tag, "_ae"},    32'(s_ae),    32'd1);
      chk({tag, "_af"},    32'(s_af),    32'd0);
      chk({tag, "_dout"},  32'(s_dout),  32'd0);
      chk({tag, "_dv"},    32'(s_dv),    32'd0);
      chk({tag, "_ovf"},   32'(s_ovf),   32'd0);
      chk({tag, "_unf"},   32'(s_unf),   32'd0);
      chk({tag, "_f_dv"},  32'(f_dv),    32'd0);
   endtask

   initial begin
      logic [7:0] sb[$];
      logic [7:0] exp_q[$];
      logic [7:0] popped;
      logic [7:0] d;
      logic       w, r, ra, wa;
      int         wrs;

      n_reset = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
      data_in = 8'h00; afull_thr = 6'd29; aempty_thr = 6'd2;
      tick();
      tick();
      chk_reset("reset");
      n_reset = 1'b0;

      // Fill 0x00..0x1F
      for (int i = 0; i < 32; i++) begin
         wr_en = 1'b1; data_in = 8'(i);
         tick();
         chk("fill_cnt",  32'(s_cnt), 32'(i + 1));
         chk("fill_full", 32'(s_full), (i == 31) ? 32'd1 : 32'd0);
         chk("fill_af",   32'(s_af), (i + 1 >= 29) ? 32'd1 : 32'd0);
         chk("fill_ae",   32'(s_ae), (i + 1 <= 2) ? 32'd1 : 32'd0);
         if (i == 0) begin
            chk("fwft_first_dout", 32'(f_dout), 32'h00);
            chk("fwft_first_dv",   32'(f_dv), 32'd1);
         end
      end
      wr_en = 1'b0;

      // Overflow and err_clr interplay
      wr_en = 1'b1; data_in = 8'hAA;
      tick();
      wr_en = 1'b0;
      chk("ovf_set", 32'(s_ovf), 32'd1);
      chk("ovf_cnt", 32'(s_cnt), 32'd32);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("ovf_clr", 32'(s_ovf), 32'd0);
      err_clr = 1'b1; wr_en = 1'b1; data_in = 8'hAB;
      tick();
      err_clr = 1'b0; wr_en = 1'b0;
      chk("ovf_set_wins", 32'(s_ovf), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("ovf_clr2", 32'(s_ovf), 32'd0);

      // Simultaneous read+write while full
      wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h55;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("rw_full_cnt",  32'(s_cnt), 32'd32);
      chk("rw_full_dout", 32'(s_dout), 32'h00);
      chk("rw_full_dv",   32'(s_dv), 32'd1);
      chk("rw_full_ovf",  32'(s_ovf), 32'd0);
      chk("rw_full_fdout", 32'(f_dout), 32'h01);

      // Drain: 0x01..0x1F then 0x55
      for (int k = 1; k < 32; k++) exp_q.push_back(8'(k));
      exp_q.push_back(8'h55);
      for (int k = 0; k < 32; k++) begin
         rd_en = 1'b1;
         tick();
         chk("drain_dout", 32'(s_dout), 32'(exp_q[k]));
         chk("drain_dv",   32'(s_dv), 32'd1);
         chk("drain_cnt",  32'(s_cnt), 32'(31 - k));
         chk("drain_ae",   32'(s_ae), (31 - k <= 2) ? 32'd1 : 32'd0);
         if (k < 31) chk("drain_fdout", 32'(f_dout), 32'(exp_q[k + 1]));
      end
      rd_en = 1'b0;
      tick();
      chk("drain_dv_off", 32'(s_dv), 32'd0);
      chk("drain_hold",   32'(s_dout), 32'h55);
      chk("drain_empty",  32'(s_empty), 32'd1);
      chk("drain_fempty", 32'(f_empty), 32'd1);
      chk("drain_fdv",    32'(f_dv), 32'd0);

      // Underflow and clear
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("unf_set", 32'(s_unf), 32'd1);
      chk("unf_cnt", 32'(s_cnt), 32'd0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("unf_clr", 32'(s_unf), 32'd0);
      chk("unf_clr_ovf", 32'(s_ovf), 32'd0);

      // Simultaneous read+write while empty, doubles as FWFT write-to-empty
      wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h3C;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("rw_empty_cnt", 32'(s_cnt), 32'd1);
      chk("rw_empty_unf", 32'(s_unf), 32'd1);
      chk("rw_empty_dv",  32'(s_dv), 32'd0);
      chk("fwft_dout",    32'(f_dout), 32'h3C);
      chk("fwft_dv",      32'(f_dv), 32'd1);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("pop_dout",     32'(s_dout), 32'h3C);
      chk("pop_dv",       32'(s_dv), 32'd1);
      chk("fwft_pop_dv",  32'(f_dv), 32'd0);
      chk("fwft_pop_emp", 32'(f_empty), 32'd1);

      // Random interleave with scoreboard; 100 writes wrap the pointers several times
      wrs = 0;
      for (int c = 0; c < 3000 && (wrs < 100 || sb.size() > 0); c++) begin
         w  = (wrs < 100) && ($urandom_range(0, 2) != 0);
         r  = (wrs >= 100) || ($urandom_range(0, 1) == 1);
         d  = 8'($urandom_range(0, 255));
         ra = r && (sb.size() > 0);
         wa = w && ((sb.size() < 32) || ra);
         wr_en = w; rd_en = r; data_in = d;
         tick();
         if (ra) popped = sb.pop_front();
         if (wa) begin
            sb.push_back(d);
            wrs++;
         end
         chk("rand_cnt", 32'(s_cnt), 32'(sb.size()));
         if (ra) begin
            chk("rand_dout", 32'(s_dout), 32'(popped));
            chk("rand_dv",   32'(s_dv), 32'd1);
         end
         if (sb.size() > 0) chk("rand_fdout", 32'(f_dout), 32'(sb[0]));
      end
      wr_en = 1'b0; rd_en = 1'b0;
      chk("rand_empty", 32'(s_empty), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;

      // Build count=10 with overflow set, then flush with a concurrent write
      for (int i = 0; i < 32; i++) begin
         wr_en = 1'b1; data_in = 8'(i);
         tick();
      end
      data_in = 8'hEE;
      tick();
      wr_en = 1'b0;
      chk("pre_flush_ovf", 32'(s_ovf), 32'd1);
      rd_en = 1'b1;
      repeat (22) tick();
      rd_en = 1'b0;
      chk("pre_flush_cnt",  32'(s_cnt), 32'd10);
      chk("pre_flush_dout", 32'(s_dout), 32'h15);
      aempty_thr = 6'd32; #1;
      chk("thr_ae_max", 32'(s_ae), 32'd1);
      afull_thr = 6'd10; #1;
      chk("thr_af_eq", 32'(s_af), 32'd1);
      afull_thr = 6'd11; #1;
      chk("thr_af_above", 32'(s_af), 32'd0);
      afull_thr = 6'd29; aempty_thr = 6'd2; #1;
      chk("thr_ae_restore", 32'(s_ae), 32'd0);

      flush = 1'b1; wr_en = 1'b1; data_in = 8'h99;
      tick();
      flush = 1'b0; wr_en = 1'b0;
      chk("flush_cnt",   32'(s_cnt), 32'd0);
      chk("flush_empty", 32'(s_empty), 32'd1);
      chk("flush_ovf",   32'(s_ovf), 32'd1);
      chk("flush_dv",    32'(s_dv), 32'd0);
      chk("flush_dout",  32'(s_dout), 32'h15);
      chk("flush_fdv",   32'(f_dv), 32'd0);
      wr_en = 1'b1; data_in = 8'h77;
      tick();
      wr_en = 1'b0; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("post_flush_dout", 32'(s_dout), 32'h77);
      chk("post_flush_cnt",  32'(s_cnt), 32'd0);

      // Reset mid-stream with flags set and a write in flight
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("pre_rst_unf", 32'(s_unf), 32'd1);
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; data_in = 8'(8'hC0 + i);
         tick();
      end
      n_reset = 1'b1; data_in = 8'hC3;
      tick();
      n_reset = 1'b0; wr_en = 1'b0;
      chk_reset("midrst");
      afull_thr = 6'd0; #1;
      chk("thr_af_zero", 32'(s_af), 32'd1);
      afull_thr = 6'd29;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_fifo_prog.md
Name: uart_fifo_prog

Overview:
- Next-generation synchronous FIFO for the UART TX/RX datapaths.
- Depth is a power of two set by ADDR_W, with full 2**ADDR_W occupancy (no wasted slot).
- Selectable standard or first-word-fall-through (FWFT) read mode.
- Run-time programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags with clear, and a synchronous flush.
- Sits between the UART baud-rate engine and the bus/host side.

Parameters:
- DATA_W, 8: data word width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- FWFT, 0: 0 = standard read (1-cycle latency); 1 = first-word-fall-through.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- n_reset  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous clear of contents.
- wr_en  input  1  write request.
- data_in  input  DATA_W  write data.
- rd_en  input  1  read (pop) request.
- data_out  output  DATA_W  read data.
- data_valid  output  1  data_out holds valid popped (FWFT=0) or head (FWFT=1) data.
- afull_thr  input  ADDR_W+1  almost-full threshold, 0..DEPTH.
- aempty_thr  input  ADDR_W+1  almost-empty threshold, 0..DEPTH.
- data_count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- empty  output  1  data_count == 0.
- full  output  1  data_count == DEPTH.
- almst_full  output  1  data_count >= afull_thr.
- almst_empty  output  1  data_count <= aempty_thr.
- overflow  output  1  sticky: a write was rejected.
- underflow  output  1  sticky: a read was rejected.
- err_clr  input  1  clears overflow and underflow.

Behaviour:
- Reset (n_reset=1 at a clk edge):
  - Pointers 0, data_count 0.
  - empty=1, full=0, almst_empty=1, almst_full=0.
  - data_out=0, data_valid=0, overflow=0, underflow=0.
  - Memory contents are not cleared.
- Priority: reset > flush > normal operation.
- Flush:
  - Pointers and count go to 0; wr_en/rd_en in the same cycle are ignored.
  - data_valid goes to 0.
  - data_out and the sticky flags keep their values.
- Pointers: ADDR_W bits, wrap naturally from DEPTH-1 to 0. data_count is the registered occupancy.
- Write accept: wr_acc = wr_en & (!full | rd_acc). A write while full is accepted when a read is accepted in the same cycle.
- Read accept: rd_acc = rd_en & !empty. A read while empty is rejected even if a write is accepted in the same cycle.
- Count update:
  - wr_acc only: +1.
  - rd_acc only: -1.
  - Both or neither: unchanged.
- Status flags are combinational from the registered data_count and the threshold inputs, so they reflect an operation on the cycle after it.
- Sticky flags:
  - overflow is set on (wr_en & !wr_acc); underflow is set on (rd_en & !rd_acc).
  - err_clr clears both on the next edge.
  - If a new error occurs in the same cycle as err_clr, set wins.
- FWFT=0:
  - On rd_acc, data_out <= mem[rd_ptr] at that edge; data_valid=1 for exactly that following cycle, else 0.
  - data_out holds its last value otherwise.
- FWFT=1:
  - data_out = mem[rd_ptr], asynchronous read; data_valid = !empty.
  - rd_acc advances to the next word, visible the cycle after.
  - A write into an empty FIFO appears on data_out one cycle after the write edge.
- Same-address write/read while full:
  - The read returns the old word.
  - The write lands after the read, at the freed slot, because wr_ptr == rd_ptr only when full or empty.
- Thresholds may change at any time; the flags follow immediately, combinationally.
  - afull_thr=0 gives almst_full=1 permanently.
  - aempty_thr=DEPTH gives almst_empty=1 permanently.
- Reset mid-operation discards all contents; there is no partial-write corruption of pointers.

Decomposition:
- Shared package uart_fifo_pkg:
  - Constant default widths.
  - Function depth_of(ADDR_W).
  - Enumerated read-mode constants MODE_STD=0, MODE_FWFT=1.
- Sub-module fifo_ram_dp:
  - Dual-port array, DATA_W x DEPTH, with synchronous write.
  - Read port is registered or asynchronous, selected by a parameter.
  - No reset on the array.
- Top level holds the pointers, counter, flags, and the accept logic.

Test Plan:
- Fill/drain (DEPTH=32, FWFT=0, afull_thr=29, aempty_thr=2):
  - Write 0x00..0x1F: full=1 after the 32nd write; almst_full rises when count reaches 29.
  - Drain: data_out = 0x00..0x1F in order, each with a 1-cycle data_valid pulse, 1 cycle after rd_en; empty=1 at the end.
- Overflow/underflow:
  - Write 0xAA while full -> overflow=1, count stays 32.
  - rd_en while empty -> underflow=1.
  - err_clr -> both 0 next cycle.
  - err_clr together with a new bad write -> overflow stays 1.
- Simultaneous rd+wr:
  - At count=32: both accepted, count stays 32, and 0x55 appears after the existing words.
  - At count=0: write accepted, read rejected, count=1, underflow=1.
- FWFT=1:
  - Write 0x3C into empty: data_out=0x3C and data_valid=1 one cycle later.
  - Pop: data_valid=0 and empty=1 on the next cycle.
- Wrap-around: 100 interleaved writes/reads with random gaps; scoreboard matches all data; pointers wrap three or more times.
- Flush at count=10 with wr_en=1 in the same cycle -> count=0, empty=1, write discarded, overflow unchanged. Assert n_reset mid-stream -> all outputs at reset values next cycle.
